regfile_wb_arbiter: RTL and testbench

- Shares the register file's single byte-enabled write port between NUM_REQ writeback requesters:
  - req 0: main pipeline WB stage.
  - req 1..N-1: long-latency sources such as the divider and uncached-load return.
- Arbitration is fixed priority (req 0 highest) with per-requester aging, so slow units cannot starve.
- The granted write passes through a one-entry staging register, then drives the regfile write port.
- Read bypass merges the staged bytes into regfile read data, so readers never see stale values.

---
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single byte-enabled write port.
// Fixed priority with aging, a one-entry staging register, and read bypass of staged bytes.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*4-1:0]    req_be,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [3:0]              rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  input  logic [4:0]              rd_addr1,
  input  logic [31:0]             rf_rdata1,
  output logic [31:0]             rd_data1,
  input  logic [4:0]              rd_addr2,
  input  logic [31:0]             rf_rdata2,
  output logic [31:0]             rd_data2
);

  // Handshake: a request transfers on any cycle where req_valid[i] & req_ready[i];
  // the requester holds addr/be/data stable from valid until that cycle.

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [NUM_REQ-1:0]        grant;
  logic                      found;
  logic [NUM_REQ-1:1][3:0]   wait_cnt_q, wait_cnt_d;
  logic                      stg_v_q, stg_v_d;
  logic [4:0]                stg_addr_q, stg_addr_d;
  logic [3:0]                stg_be_q, stg_be_d;
  logic [31:0]               stg_data_q, stg_data_d;

  // Starved requesters (counter saturated) outrank plain fixed priority.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (wait_cnt_q[i] == MAX_W)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (reset) grant = '0;
  end

  always_comb begin
    wait_cnt_d = '0;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (req_valid[i] && !grant[i])
        wait_cnt_d[i] = (wait_cnt_q[i] == MAX_W) ? MAX_W : wait_cnt_q[i] + 4'd1;
    end
  end

  // Writes to r0 are accepted but staged with no byte enables.
  always_comb begin
    stg_v_d    = 1'b0;
    stg_addr_d = '0;
    stg_be_d   = '0;
    stg_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        stg_v_d    = 1'b1;
        stg_addr_d = req_addr[5*i +: 5];
        stg_be_d   = (req_addr[5*i +: 5] == 5'd0) ? 4'h0 : req_be[4*i +: 4];
        stg_data_d = req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      stg_v_q    <= 1'b0;
      stg_addr_q <= '0;
      stg_be_q   <= '0;
      stg_data_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      stg_v_q    <= stg_v_d;
      stg_addr_q <= stg_addr_d;
      stg_be_q   <= stg_be_d;
      stg_data_q <= stg_data_d;
    end
  end

  assign req_ready = grant;
  // Gated by reset so a write staged just before reset never reaches the regfile.
  assign rf_we     = (stg_v_q && !reset) ? stg_be_q : 4'h0;
  assign rf_waddr  = stg_addr_q;
  assign rf_wdata  = stg_data_q;

  always_comb begin
    rd_data1 = rf_rdata1;
    rd_data2 = rf_rdata2;
    for (int j = 0; j < 4; j++) begin
      if (stg_v_q && (stg_addr_q == rd_addr1) && (rd_addr1 != 5'd0) && stg_be_q[j])
        rd_data1[8*j +: 8] = stg_data_q[8*j +: 8];
      if (stg_v_q && (stg_addr_q == rd_addr2) && (rd_addr2 != 5'd0) && stg_be_q[j])
        rd_data2[8*j +: 8] = stg_data_q[8*j +: 8];
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants, aging, staging latency, bypass and reset.
// Expected write-port traffic is queued and checked in order by a write monitor.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*5-1:0]  req_addr;
  logic [NUM_REQ*4-1:0]  req_be;
  logic [NUM_REQ*32-1:0] req_data;
  logic [3:0]            rf_we;
  logic [4:0]            rf_waddr;
  logic [31:0]           rf_wdata;
  logic [4:0]            rd_addr1, rd_addr2;
  logic [31:0]           rf_rdata1, rf_rdata2, rd_data1, rd_data2;

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [40:0] exp_q[$];
  logic [40:0] mon_e;
  logic [2:0]  exp_r;
  logic [31:0] req0_d;
  logic [2:0]  tie_exp [7];

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_be(req_be), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rf_rdata1(rf_rdata1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rf_rdata2(rf_rdata2), .rd_data2(rd_data2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [3:0] be,
                         input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_be[i*4 +: 4]     = be;
    req_data[i*32 +: 32] = d;
    req_valid[i]         = 1'b1;
  endtask

  // scoreboard: every non-empty write must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && rf_we != 4'h0) begin
      if (exp_q.size() == 0) begin
        check_val("wr_unexpected", {23'h0, rf_we, rf_waddr, rf_wdata}, 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_port", {23'h0, rf_we, rf_waddr, rf_wdata}, {23'h0, mon_e});
      end
    end
  end

  initial begin
    tie_exp[0] = 3'b001; tie_exp[1] = 3'b001; tie_exp[2] = 3'b001; tie_exp[3] = 3'b001;
    tie_exp[4] = 3'b010; tie_exp[5] = 3'b100; tie_exp[6] = 3'b001;
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_be = '0; req_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    set_req(0, 5'd1, 4'hF, 32'h0BAD_0BAD);
    tick(); tick();
    check_val("rst_ready", req_ready, 0);
    check_val("rst_we", rf_we, 0);
    tick();
    reset = 1'b0;
    req_valid = '0;
    tick();

    // single write through the stage
    set_req(1, 5'd5, 4'hF, 32'h1234_5678);
    #1;
    check_val("single_ready", req_ready, 3'b010);
    exp_q.push_back({4'hF, 5'd5, 32'h1234_5678});
    tick();
    req_valid = '0;
    #1;
    check_val("single_we", rf_we, 4'hF);
    check_val("single_waddr", rf_waddr, 5);
    check_val("single_wdata", rf_wdata, 32'h1234_5678);
    check_val("single_ready_off", req_ready, 0);
    tick();

    // priority and aging: req1 wins in cycles 4 and 9
    req0_d = 32'h1000_0000;
    set_req(1, 5'd2, 4'hF, 32'h2000_0001);
    for (int c = 0; c < 10; c++) begin
      set_req(0, 5'd1, 4'hF, req0_d);
      #1;
      exp_r = (c == 4 || c == 9) ? 3'b010 : 3'b001;
      check_val($sformatf("age_c%0d", c), req_ready, exp_r);
      if (exp_r == 3'b010) begin
        exp_q.push_back({4'hF, 5'd2, req_data[63:32]});
        tick();
        set_req(1, 5'd2, 4'hF, 32'h2000_0002);
      end else begin
        exp_q.push_back({4'hF, 5'd1, req0_d});
        req0_d = req0_d + 32'd1;
        tick();
      end
    end
    req_valid = '0;
    tick(); tick();

    // byte-merge bypass
    set_req(1, 5'd7, 4'b0011, 32'hAAAA_BBBB);
    exp_q.push_back({4'b0011, 5'd7, 32'hAAAA_BBBB});
    tick();
    req_valid = '0;
    rd_addr1 = 5'd7; rf_rdata1 = 32'h1111_2222;
    rd_addr2 = 5'd8; rf_rdata2 = 32'h3333_4444;
    #1;
    check_val("byp_we", rf_we, 4'b0011);
    check_val("byp_rd1", rd_data1, 32'h1111_BBBB);
    check_val("byp_rd2_miss", rd_data2, 32'h3333_4444);
    rd_addr2 = 5'd7; rf_rdata2 = 32'h0;
    #1;
    check_val("byp_rd2_hit", rd_data2, 32'h0000_BBBB);
    tick();
    #1;
    check_val("byp_expired", rd_data1, 32'h1111_2222);

    // addr 0 and empty byte enables are accepted but never written
    set_req(2, 5'd0, 4'hF, 32'hFFFF_FFFF);
    #1;
    check_val("a0_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    rd_addr1 = 5'd0; rf_rdata1 = 32'h0;
    #1;
    check_val("a0_we", rf_we, 0);
    check_val("a0_rd1", rd_data1, 0);
    set_req(1, 5'd9, 4'h0, 32'hCAFE_F00D);
    #1;
    check_val("be0_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    check_val("be0_we", rf_we, 0);
    tick();

    // reset mid-operation: staged r3 write is dropped, pending req1 re-arbitrated
    set_req(0, 5'd3, 4'hF, 32'hDEAD_BEEF);
    set_req(1, 5'd4, 4'hF, 32'h0000_0044);
    #1;
    check_val("rst_mid_grant", req_ready, 3'b001);
    tick();
    reset = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    check_val("rst_mid_ready", req_ready, 0);
    check_val("rst_mid_we", rf_we, 0);
    tick();
    reset = 1'b0;
    #1;
    check_val("rst_wait_cnt", dut.wait_cnt_q[1], 0);
    check_val("rst_after_we", rf_we, 0);
    check_val("rst_rearb", req_ready, 3'b010);
    exp_q.push_back({4'hF, 5'd4, 32'h0000_0044});
    tick();
    req_valid = '0;
    tick();

    // starved tie: req1 then req2 then req0
    req0_d = 32'h5000_0000;
    set_req(1, 5'd11, 4'hF, 32'h6000_0001);
    set_req(2, 5'd12, 4'hF, 32'h7000_0002);
    for (int c = 0; c < 7; c++) begin
      set_req(0, 5'd10, 4'hF, req0_d);
      #1;
      check_val($sformatf("tie_c%0d", c), req_ready, tie_exp[c]);
      if (tie_exp[c] == 3'b010) begin
        exp_q.push_back({4'hF, 5'd11, 32'h6000_0001});
        tick();
        req_valid[1] = 1'b0;
      end else if (tie_exp[c] == 3'b100) begin
        exp_q.push_back({4'hF, 5'd12, 32'h7000_0002});
        tick();
        req_valid[2] = 1'b0;
      end else begin
        exp_q.push_back({4'hF, 5'd10, req0_d});
        req0_d = req0_d + 32'd1;
        tick();
      end
    end
    req_valid = '0;
    tick(); tick(); tick();

    check_val("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
